// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock sequencer: state encodings
// and the width helpers used to size the index, tries and timer fields.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_SET     = 3'd5
  } state_e;

  // Bits needed to index a digit; never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

  // Bits needed to hold a tries count from 0 up to max_tries.
  function automatic int tries_width(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // Bits needed for the shared lockout/relock down-counter.
  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Synchronous rising-edge detector for one debounced button level.
// A level held high produces exactly one pulse, in the cycle it first rises.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev_d;
  logic prev_q;

  // The remembered level is simply this cycle's level.
  always_comb begin
    prev_d = level;
  end

  // Hold the previous level; cleared on reset so buttons start "released".
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign pulse = level & ~prev_q;

endmodule

// File: rtl/lock_controller.sv
// Combination-lock sequencer: steps the user through code entry, checks it
// against the stored password, counts failures with a lockout period,
// auto-relocks after a timeout and lets an unlocked user change the password.
module lock_controller
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 250_000_000,
  parameter int RELOCK_CYCLES  = 500_000_000,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PW = 32'h1234_5678
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                btn_next,
  input  logic                                btn_set,
  input  logic [3:0]                          digit_in,
  output logic [2:0]                          state,
  output logic [idx_width(NUM_DIGITS)-1:0]    digit_idx,
  output logic [4*NUM_DIGITS-1:0]             entry_digits,
  output logic                                unlocked,
  output logic                                locked_out,
  output logic [tries_width(MAX_TRIES)-1:0]   tries_left,
  output logic                                fail_pulse
);

  localparam int CODE_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int TRY_W  = tries_width(MAX_TRIES);
  localparam int TMR_W  = timer_width(LOCKOUT_CYCLES, RELOCK_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] TRIES_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] RELOCK_LOAD = TMR_W'(RELOCK_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

  // Replace the 4-bit slot selected by idx with d.
  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] code,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [3:0]        d);
    logic [CODE_W-1:0] res;
    res = code;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) res[4*i +: 4] = d;
    end
    return res;
  endfunction

  logic next_edge;
  logic set_edge;

  edge_detect u_next_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_next),
    .pulse (next_edge)
  );

  edge_detect u_set_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_set),
    .pulse (set_edge)
  );

  state_e            state_d,    state_q;
  logic [IDX_W-1:0]  idx_d,      idx_q;
  logic [CODE_W-1:0] entry_d,    entry_q;
  logic [CODE_W-1:0] stage_d,    stage_q;
  logic [CODE_W-1:0] pw_d,       pw_q;
  logic [TRY_W-1:0]  tries_d,    tries_q;
  logic [TMR_W-1:0]  timer_d,    timer_q;
  logic              fail_d,     fail_q;
  logic              unlocked_d, unlocked_q;
  logic              locked_d,   locked_q;

  // Next-state and datapath updates; one shared timer serves OPEN and LOCKOUT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    stage_d = stage_q;
    pw_d    = pw_q;
    tries_d = tries_q;
    timer_d = timer_q;
    fail_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (next_edge) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          entry_d = '0;
        end
      end

      ST_ENTRY: begin
        if (next_edge) begin
          entry_d = put_digit(entry_q, idx_q, digit_in);
          if (idx_q == LAST_IDX) state_d = ST_CHECK;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end

      ST_CHECK: begin
        if (entry_q == pw_q) begin
          state_d = ST_OPEN;
          tries_d = TRIES_MAX;
          timer_d = RELOCK_LOAD;
        end else begin
          fail_d = 1'b1;
          if (tries_q <= TRY_W'(1)) begin
            state_d = ST_LOCKOUT;
            tries_d = '0;
            timer_d = LOCK_LOAD;
          end else begin
            state_d = ST_IDLE;
            tries_d = tries_q - TRY_W'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        // Expire on the cycle the count would reach zero, so a load of N
        // leaves LOCKOUT exactly N cycles after entry.
        if (timer_q <= TMR_ONE) begin
          state_d = ST_IDLE;
          tries_d = TRIES_MAX;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_OPEN: begin
        if (set_edge) begin
          state_d = ST_SET;
          idx_d   = '0;
          entry_d = '0;
          stage_d = '0;
        end else if (next_edge) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q <= TMR_ONE) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_SET: begin
        // Timer stays frozen here; it is reloaded on the way back to OPEN.
        if (set_edge) begin
          state_d = ST_OPEN;
          timer_d = RELOCK_LOAD;
        end else if (next_edge) begin
          stage_d = put_digit(stage_q, idx_q, digit_in);
          if (idx_q == LAST_IDX) begin
            pw_d    = stage_d;
            state_d = ST_OPEN;
            timer_d = RELOCK_LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
    locked_d   = (state_d == ST_LOCKOUT);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      entry_q    <= '0;
      stage_q    <= '0;
      pw_q       <= DEFAULT_PW;
      tries_q    <= TRIES_MAX;
      timer_q    <= '0;
      fail_q     <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      stage_q    <= stage_d;
      pw_q       <= pw_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  assign state        = state_q;
  assign digit_idx    = idx_q;
  assign entry_digits = entry_q;
  assign unlocked     = unlocked_q;
  assign locked_out   = locked_q;
  assign tries_left   = tries_q;
  assign fail_pulse   = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios followed by randomized
// attempts, all predicted by a transaction-level model of the lock.
module tb_lock_controller;

  localparam int ND = 4;
  localparam int MT = 2;
  localparam int LC = 20;
  localparam int RC = 30;
  localparam logic [15:0] DPW = 16'h4321;

  localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_OPEN = 3, S_LOCKOUT = 4, S_SET = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_set = 1'b0;
  logic [3:0]  digit_in = 4'h0;
  logic [2:0]  state;
  logic [1:0]  digit_idx;
  logic [15:0] entry_digits;
  logic        unlocked;
  logic        locked_out;
  logic [1:0]  tries_left;
  logic        fail_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int open_t = 0;
  int lock_t = 0;

  // Model of the lock: stored password, remaining tries, coarse status.
  logic [15:0] m_pw;
  int          m_tries;
  int          m_st;
  logic [15:0] code;

  lock_controller #(
    .NUM_DIGITS     (ND),
    .MAX_TRIES      (MT),
    .LOCKOUT_CYCLES (LC),
    .RELOCK_CYCLES  (RC),
    .DEFAULT_PW     (DPW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_next     (btn_next),
    .btn_set      (btn_set),
    .digit_in     (digit_in),
    .state        (state),
    .digit_idx    (digit_idx),
    .entry_digits (entry_digits),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .tries_left   (tries_left),
    .fail_pulse   (fail_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_state", 32'(state), S_IDLE);
    chk("rst_idx", 32'(digit_idx), 0);
    chk("rst_entry", 32'(entry_digits), 0);
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_locked", 32'(locked_out), 0);
    chk("rst_tries", 32'(tries_left), MT);
    chk("rst_fail", 32'(fail_pulse), 0);
  endtask

  // One full attempt from IDLE: wake, dial all digits, check the verdict.
  task automatic attempt(input logic [15:0] c);
    logic [15:0] shown;
    int hold;
    shown = '0;
    chk("pre_idle", 32'(state), S_IDLE);
    btn_next = 1'b1; digit_in = 4'($urandom); tick();
    chk("wake_state", 32'(state), S_ENTRY);
    chk("wake_idx", 32'(digit_idx), 0);
    chk("wake_clear", 32'(entry_digits), 0);
    btn_next = 1'b0; tick();
    for (int i = 0; i < ND; i++) begin
      digit_in = c[4*i +: 4]; btn_next = 1'b1; tick();
      shown[4*i +: 4] = c[4*i +: 4];
      if (i < ND - 1) begin
        chk("entry_state", 32'(state), S_ENTRY);
        chk("entry_idx", 32'(digit_idx), i + 1);
        chk("entry_digits", 32'(entry_digits), 32'(shown));
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) tick();
        chk("held_idx", 32'(digit_idx), i + 1);
        btn_next = 1'b0; digit_in = 4'($urandom); tick();
        if ($urandom_range(0, 1) == 1) tick();
      end else begin
        chk("check_state", 32'(state), S_CHECK);
        chk("check_entry", 32'(entry_digits), 32'(shown));
        btn_next = 1'b0; tick();
        if (c == m_pw) begin
          m_tries = MT; m_st = S_OPEN; open_t = cyc;
        end else begin
          m_tries = m_tries - 1;
          if (m_tries == 0) begin m_st = S_LOCKOUT; lock_t = cyc; end
          else m_st = S_IDLE;
        end
        chk("verdict_state", 32'(state), 32'(m_st));
        chk("verdict_tries", 32'(tries_left), 32'(m_tries));
        chk("verdict_unlocked", 32'(unlocked), (m_st == S_OPEN) ? 1 : 0);
        chk("verdict_locked", 32'(locked_out), (m_st == S_LOCKOUT) ? 1 : 0);
        chk("fail_pulse_on", 32'(fail_pulse), (m_st == S_OPEN) ? 0 : 1);
        tick();
        chk("fail_pulse_off", 32'(fail_pulse), 0);
      end
    end
  endtask

  // Sit out the lockout while hammering buttons; they must change nothing.
  task automatic lockout_wait();
    while (cyc < lock_t + LC) begin
      if (cyc < lock_t + LC - 1) begin
        btn_next = 1'($urandom_range(0, 1));
        btn_set  = 1'($urandom_range(0, 1));
      end else begin
        btn_next = 1'b0; btn_set = 1'b0;
      end
      tick();
      if (cyc < lock_t + LC) begin
        chk("lockout_state", 32'(state), S_LOCKOUT);
        chk("lockout_flag", 32'(locked_out), 1);
        chk("lockout_tries", 32'(tries_left), 0);
      end
    end
    m_tries = MT; m_st = S_IDLE;
    chk("lockout_exit_state", 32'(state), S_IDLE);
    chk("lockout_exit_flag", 32'(locked_out), 0);
    chk("lockout_exit_tries", 32'(tries_left), MT);
  endtask

  // Actions from OPEN: 0 timeout, 1 manual relock, 2 set sequence,
  // 3 set sequence started by simultaneous next+set. Fewer than ND digits aborts.
  task automatic open_action(input int act, input int ndig, input logic [15:0] newpw);
    if (act == 0) begin
      while (cyc < open_t + RC - 1) tick();
      chk("relock_pre", 32'(state), S_OPEN);
      tick();
      chk("relock_timeout", 32'(state), S_IDLE);
      chk("relock_unlocked", 32'(unlocked), 0);
      m_st = S_IDLE;
    end else if (act == 1) begin
      btn_next = 1'b1; tick();
      chk("manual_relock", 32'(state), S_IDLE);
      chk("manual_unlocked", 32'(unlocked), 0);
      btn_next = 1'b0; tick();
      m_st = S_IDLE;
    end else begin
      btn_set = 1'b1;
      if (act == 3) btn_next = 1'b1;
      tick();
      chk("set_state", 32'(state), S_SET);
      chk("set_idx", 32'(digit_idx), 0);
      chk("set_clear", 32'(entry_digits), 0);
      chk("set_unlocked", 32'(unlocked), 0);
      btn_set = 1'b0; btn_next = 1'b0; tick();
      for (int i = 0; i < ndig; i++) begin
        digit_in = newpw[4*i +: 4]; btn_next = 1'b1; tick();
        if (i < ND - 1) begin
          chk("set_dig_state", 32'(state), S_SET);
          chk("set_dig_idx", 32'(digit_idx), i + 1);
        end else begin
          m_pw = newpw; open_t = cyc;
          chk("set_done_state", 32'(state), S_OPEN);
          chk("set_done_unlocked", 32'(unlocked), 1);
        end
        btn_next = 1'b0; tick();
      end
      if (ndig < ND) begin
        btn_set = 1'b1; btn_next = 1'($urandom_range(0, 1)); tick();
        open_t = cyc;
        chk("abort_state", 32'(state), S_OPEN);
        chk("abort_unlocked", 32'(unlocked), 1);
        btn_set = 1'b0; btn_next = 1'b0; tick();
      end
      m_st = S_OPEN;
    end
  endtask

  initial begin
    m_pw = DPW; m_tries = MT; m_st = S_IDLE;

    rst_n = 1'b0; tick();
    chk_reset();
    tick(); rst_n = 1'b1;

    // Correct default code opens, then relocks on timeout.
    attempt(16'h4321);
    open_action(0, 0, 16'h0);

    // Two wrong codes lead to lockout; buttons ignored until it ends.
    attempt(16'h5321);
    attempt(16'h5321);
    lockout_wait();

    // Change password to 9999, relock, old code fails, new code opens.
    attempt(DPW);
    open_action(2, ND, 16'h9999);
    open_action(1, 0, 16'h0);
    attempt(16'h9999);
    open_action(1, 0, 16'h0);
    attempt(16'h4321);
    attempt(16'h9999);

    // Abort after two digits keeps the old password; then relock via timer.
    open_action(2, 2, 16'h1111);
    open_action(0, 0, 16'h0);
    attempt(16'h9999);

    // Simultaneous next+set in OPEN goes to SET; abort at once.
    open_action(3, 0, 16'h0);
    open_action(1, 0, 16'h0);

    // Burn one try, then hold next for 10 cycles inside ENTRY.
    attempt(16'h0000);
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    digit_in = 4'h7; btn_next = 1'b1;
    for (int h = 0; h < 10; h++) tick();
    chk("hold_idx", 32'(digit_idx), 1);
    chk("hold_entry", 32'(entry_digits), 32'h7);
    btn_next = 1'b0; tick();

    // Reset mid-ENTRY restores everything, including password and tries.
    rst_n = 1'b0; tick();
    chk_reset();
    rst_n = 1'b1;
    m_pw = DPW; m_tries = MT; m_st = S_IDLE;
    attempt(16'h4321);

    // Program a new password, then reset mid-SET: default password returns.
    open_action(2, ND, 16'h8765);
    btn_set = 1'b1; tick();
    btn_set = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      digit_in = 4'($urandom); btn_next = 1'b1; tick();
      btn_next = 1'b0; tick();
    end
    rst_n = 1'b0; tick();
    chk_reset();
    rst_n = 1'b1;
    m_pw = DPW; m_tries = MT; m_st = S_IDLE;
    attempt(16'h8765);
    attempt(DPW);
    open_action(1, 0, 16'h0);

    // Randomized attempts and OPEN-state activity against the model.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) code = m_pw;
      else                           code = 16'($urandom);
      attempt(code);
      if (m_st == S_OPEN) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++)
          open_action($urandom_range(2, 3), $urandom_range(0, ND), 16'($urandom));
        open_action($urandom_range(0, 1), 0, 16'h0);
      end else if (m_st == S_LOCKOUT) begin
        lockout_wait();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
